// File: rtl/axi_refill_responder.sv
// AXI4 read-only subordinate for cache refills: buffers AR requests in a small FIFO
// and serves each burst beat by beat from a synchronous single-port memory.
module axi_refill_responder #(
  parameter int unsigned               AxiIdWidth   = 4,
  parameter int unsigned               AxiAddrWidth = 64,
  parameter int unsigned               AxiDataWidth = 64,
  parameter logic [AxiAddrWidth-1:0]   RegionBase   = 64'h8000_0000,
  parameter logic [AxiAddrWidth-1:0]   RegionLength = 64'h4000_0000,
  parameter int unsigned               ReqFifoDepth = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  input  logic [AxiIdWidth-1:0]   ar_id_i,
  input  logic [AxiAddrWidth-1:0] ar_addr_i,
  input  logic [7:0]              ar_len_i,
  input  logic [2:0]              ar_size_i,
  input  logic [1:0]              ar_burst_i,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [AxiIdWidth-1:0]   r_id_o,
  output logic [AxiDataWidth-1:0] r_data_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_last_o,
  output logic                    mem_req_o,
  output logic [AxiAddrWidth-1:0] mem_addr_o,
  input  logic [AxiDataWidth-1:0] mem_rdata_i
);

  localparam int unsigned IdxW = (ReqFifoDepth > 1) ? $clog2(ReqFifoDepth) : 1;
  localparam int unsigned CntW = $clog2(ReqFifoDepth + 1);
  localparam logic [AxiAddrWidth:0]   RegionEnd = {1'b0, RegionBase} + {1'b0, RegionLength};
  localparam logic [AxiAddrWidth-1:0] WordMask  =
    ~(AxiAddrWidth'(AxiDataWidth / 8) - AxiAddrWidth'(1));

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } req_t;

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_FILL, ST_RESP} state_e;

  req_t                    fifo_mem_r [ReqFifoDepth];
  logic [IdxW-1:0]         wr_idx_r, rd_idx_r;
  logic [CntW-1:0]         count_r, count_next_s;
  logic                    ar_ready_r;
  logic                    push_s, pop_s;

  state_e                  state_r, state_next_s;
  logic [AxiIdWidth-1:0]   id_r;
  logic [AxiAddrWidth-1:0] addr_r, addr_next_s;
  logic [7:0]              len_r, beat_cnt_r;
  logic [2:0]              size_r;
  logic [1:0]              burst_r;
  logic [1:0]              resp_s;
  logic                    wrap_len_ok_s;
  logic [AxiAddrWidth-1:0] step_s, wrap_mask_s;

  logic                    r_valid_r, r_last_r;
  logic [1:0]              r_resp_r;
  logic [AxiDataWidth-1:0] r_data_r;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
    if (idx == IdxW'(ReqFifoDepth - 1)) begin
      return {IdxW{1'b0}};
    end else begin
      return idx + IdxW'(1);
    end
  endfunction

  assign push_s = ar_valid_i & ar_ready_r;
  assign pop_s  = (state_r == ST_IDLE) && (count_r != {CntW{1'b0}});

  // FIFO occupancy for the next cycle
  always_comb begin
    count_next_s = count_r;
    if (push_s && !pop_s) begin
      count_next_s = count_r + CntW'(1);
    end else if (!push_s && pop_s) begin
      count_next_s = count_r - CntW'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // FIFO pointers, occupancy and the registered not-full flag that drives ar_ready
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_idx_r   <= {IdxW{1'b0}};
      rd_idx_r   <= {IdxW{1'b0}};
      count_r    <= {CntW{1'b0}};
      ar_ready_r <= 1'b0;
    end else begin
      if (push_s) wr_idx_r <= next_idx(wr_idx_r);
      if (pop_s)  rd_idx_r <= next_idx(rd_idx_r);
      count_r    <= count_next_s;
      ar_ready_r <= (count_next_s != CntW'(ReqFifoDepth));
    end
  end

  // FIFO storage; validity is tracked by the occupancy counter only
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      fifo_mem_r[wr_idx_r] <= '{id: ar_id_i, addr: ar_addr_i, len: ar_len_i,
                                size: ar_size_i, burst: ar_burst_i};
    end
  end

  // Per-beat response decision and next beat address
  always_comb begin
    wrap_len_ok_s = (len_r == 8'd1) || (len_r == 8'd3) || (len_r == 8'd7) || (len_r == 8'd15);
    step_s        = AxiAddrWidth'(1) << size_r;
    wrap_mask_s   = ((AxiAddrWidth'(len_r) + AxiAddrWidth'(1)) << size_r) - AxiAddrWidth'(1);
    if ((burst_r == 2'b11) || ((burst_r == 2'b10) && !wrap_len_ok_s)) begin
      resp_s = RespSlverr;
    end else if (({1'b0, addr_r} < {1'b0, RegionBase}) || ({1'b0, addr_r} >= RegionEnd)) begin
      resp_s = RespDecerr;
    end else begin
      resp_s = RespOkay;
    end
    case (burst_r)
      2'b00:   addr_next_s = addr_r;
      2'b01:   addr_next_s = addr_r + step_s;
      2'b10:   addr_next_s = (addr_r & ~wrap_mask_s) | ((addr_r + step_s) & wrap_mask_s);
      default: addr_next_s = addr_r + step_s;
    endcase
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  state_next_s = pop_s ? ST_CHECK : ST_IDLE;
      ST_CHECK: state_next_s = (resp_s == RespOkay) ? ST_FILL : ST_RESP;
      ST_FILL:  state_next_s = ST_RESP;
      ST_RESP: begin
        if (r_ready_i) begin
          state_next_s = r_last_r ? ST_IDLE : ST_CHECK;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // FSM state, burst context and the R holding register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= ST_IDLE;
      id_r       <= {AxiIdWidth{1'b0}};
      addr_r     <= {AxiAddrWidth{1'b0}};
      len_r      <= 8'd0;
      size_r     <= 3'd0;
      burst_r    <= 2'b00;
      beat_cnt_r <= 8'd0;
      r_valid_r  <= 1'b0;
      r_last_r   <= 1'b0;
      r_resp_r   <= RespOkay;
      r_data_r   <= {AxiDataWidth{1'b0}};
    end else begin
      state_r   <= state_next_s;
      r_valid_r <= (state_next_s == ST_RESP);
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            id_r       <= fifo_mem_r[rd_idx_r].id;
            addr_r     <= fifo_mem_r[rd_idx_r].addr;
            len_r      <= fifo_mem_r[rd_idx_r].len;
            size_r     <= fifo_mem_r[rd_idx_r].size;
            burst_r    <= fifo_mem_r[rd_idx_r].burst;
            beat_cnt_r <= 8'd0;
          end
        end
        ST_CHECK: begin
          r_resp_r <= resp_s;
          r_last_r <= (beat_cnt_r == len_r);
          if (resp_s != RespOkay) r_data_r <= {AxiDataWidth{1'b0}};
        end
        ST_FILL: r_data_r <= mem_rdata_i;
        ST_RESP: begin
          if (r_ready_i && !r_last_r) begin
            beat_cnt_r <= beat_cnt_r + 8'd1;
            addr_r     <= addr_next_s;
          end
        end
        default: ;
      endcase
    end
  end

  assign ar_ready_o = ar_ready_r;
  assign r_valid_o  = r_valid_r;
  assign r_id_o     = id_r;
  assign r_data_o   = r_data_r;
  assign r_resp_o   = r_resp_r;
  assign r_last_o   = r_last_r;
  assign mem_req_o  = (state_r == ST_CHECK) && (resp_s == RespOkay);
  assign mem_addr_o = mem_req_o ? (addr_r & WordMask) : {AxiAddrWidth{1'b0}};

endmodule

// File: doc/axi_refill_responder.md
Name: axi_refill_responder

Overview:
- AXI4 read-only subordinate that serves cache-refill and fetch bursts issued by the core's I$/D$ AXI initiator. It is the memory-side counterpart of the refill path.
- It accepts AR requests into a small FIFO and walks each burst beat by beat against a synchronous single-port memory.
- It returns R beats with correct ID, LAST and RESP under full R-channel backpressure.
- Used in block-level testbenches and in the FPGA boot-RAM wrapper.

Parameters:
- AxiIdWidth, 4, width of ar_id_i / r_id_o
- AxiAddrWidth, 64, address width
- AxiDataWidth, 64, data width; one memory word per beat
- RegionBase, 64'h8000_0000, base of the served address window
- RegionLength, 64'h4000_0000, size of the window in bytes
- ReqFifoDepth, 2, number of AR requests buffered (power of two, ≥1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- ar_valid_i  in  1  AR valid
- ar_ready_o  out  1  AR ready
- ar_id_i  in  AxiIdWidth  AR ID
- ar_addr_i  in  AxiAddrWidth  AR start byte address
- ar_len_i  in  8  beats minus 1
- ar_size_i  in  3  log2 bytes per beat
- ar_burst_i  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- r_valid_o  out  1  R valid
- r_ready_i  in  1  R ready
- r_id_o  out  AxiIdWidth  R ID
- r_data_o  out  AxiDataWidth  R data
- r_resp_o  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- r_last_o  out  1  last beat of burst
- mem_req_o  out  1  memory read strobe
- mem_addr_o  out  AxiAddrWidth  word-aligned byte address
- mem_rdata_i  in  AxiDataWidth  read data, valid the cycle after mem_req_o

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: FIFO empty, FSM in IDLE, all outputs 0. ar_ready_o goes to 1 in the first cycle after reset deassertion.
- Reset mid-burst: everything is discarded immediately. No further R beats are produced for the aborted burst.

AR side:
- ar_ready_o = FIFO not full.
- Push on ar_valid_i & ar_ready_o.
- A push and a pop in the same cycle when the FIFO is full is not allowed; ar_ready_o depends only on the registered full flag.

FSM states and transitions:
- IDLE: if the FIFO is non-empty, load the head into burst registers (id, addr, len, size, burst, beat_cnt = 0) and pop it. Go to CHECK.
- CHECK (one cycle), decide the current beat's response:
  - ar_burst = 11 → SLVERR.
  - Otherwise, if addr < RegionBase or addr ≥ RegionBase + RegionLength → DECERR.
  - Otherwise OKAY.
  - On OKAY, assert mem_req_o with mem_addr_o = addr with the low log2(AxiDataWidth/8) bits cleared. Go to FILL.
  - On an error, go directly to RESP with data 0.
- FILL: capture mem_rdata_i into the R holding register. Go to RESP.
- RESP: r_valid_o = 1. id, data, resp and last are stable while r_ready_i = 0. On handshake:
  - If last, go to IDLE. Back-to-back FIFO entries cost one IDLE cycle.
  - Otherwise beat_cnt++, update addr, go to CHECK.
- r_last_o = (beat_cnt == len).
- The range check is performed per beat. A burst crossing the window end reports OKAY beats followed by DECERR beats.
- Throughput: 3 cycles per OKAY beat, 2 per error beat, when r_ready_i = 1.

Address update after a beat:
- step = 1 << ar_size.
- FIXED: addr unchanged.
- INCR: addr += step. 64-bit wrap-around at 2^64 is permitted and not flagged.
- WRAP: container = (len+1) << size; wrap_base = addr & ~(container-1); addr = wrap_base | ((addr + step) & (container-1)). For WRAP, len must be 1, 3, 7 or 15; other values are treated as SLVERR for every beat.
- Unaligned start addresses are served as aligned word reads. The data is not shifted.

Test Plan:
- INCR refill: id 3, addr 0x8000_0000, len 1, size 3 → two OKAY beats with data mem[0x8000_0000] and mem[0x8000_0008]. r_last_o = 0 then 1; r_id_o = 3 on both beats.
- WRAP burst: addr 0x8000_0018, len 3, size 3 → mem reads at 0x18, 0x00, 0x08, 0x10 (offsets from 0x8000_0000). r_last_o on the 4th beat only.
- Out-of-window access: addr 0x0000_1000, len 0 → one beat, r_resp_o = 11, r_data_o = 0, r_last_o = 1, mem_req_o never asserted.
- Window-end crossing: addr 0xBFFF_FFF8, len 1, INCR → beat 0 OKAY, beat 1 DECERR.
- Reserved burst type: ar_burst = 11, len 2 → three SLVERR beats, no mem_req_o.
- Backpressure and FIFO full: hold r_ready_i = 0 for 10 cycles with three AR requests offered → ar_ready_o drops after 2 accepts beyond the active burst. R payload stays stable throughout. IDs are returned in order 0, 1, 2.
- Reset mid-burst: assert rst_ni = 0 during beat 1 of a len-3 burst → r_valid_o = 0 at once. After release, no stale beats appear and ar_ready_o = 1 on the next cycle.
